// File: rtl/regbank_sequencer.sv
// regbank_sequencer: LOAD/DUMP command sequencer on the register bank ports.
// Optional feature: define REGBANK_SEQ_PARITY_EN to add the registered dp_parity output.
module regbank_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_op,
    input  logic [ADDR_W-1:0]   cmd_base,
    input  logic [ADDR_W-1:0]   cmd_len,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [DATA_W-1:0]   ld_data,
    output logic [ADDR_W-1:0]   rb_address_in,
    output logic [DATA_W-1:0]   rb_data_in,
    output logic                rb_wren,
    output logic [ADDR_W-1:0]   rb_address_a,
    output logic [ADDR_W-1:0]   rb_address_b,
    input  logic [DATA_W-1:0]   rb_q_a,
    input  logic [DATA_W-1:0]   rb_q_b,
    output logic                dp_valid,
    input  logic                dp_ready,
    output logic [2*DATA_W-1:0] dp_data,
    output logic                dp_last,
`ifdef REGBANK_SEQ_PARITY_EN
    output logic [1:0]          dp_parity,
`endif
    output logic                busy,
    output logic                done
);
    typedef enum logic [1:0] {IDLE, LOAD, DUMP, DONE} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] ptr, cnt;
    logic pad, issued;
    logic cmd_hs, ld_hs, dp_hs, dp_load, final_beat;
    logic [DATA_W-1:0] dp_lo;

    assign cmd_hs     = cmd_valid && cmd_ready;
    assign ld_hs      = ld_valid && ld_ready;
    assign dp_hs      = dp_valid && dp_ready;
    assign final_beat = cnt == '0;
    assign dp_load    = state == DUMP && !issued && (!dp_valid || dp_ready);
    assign dp_lo      = (final_beat && pad) ? '0 : rb_q_b;

    // State register; reset aborts any command in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state: command handshake starts, last word/beat handshake finishes
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = cmd_hs ? (cmd_op ? DUMP : LOAD) : IDLE;
            LOAD: state_nx = (ld_hs && final_beat) ? DONE : LOAD;
            DUMP: state_nx = (dp_hs && dp_last) ? DONE : DUMP;
            DONE: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state; bank ports are parked at 0 when unused
    always_comb begin
        cmd_ready     = state == IDLE;
        ld_ready      = state == LOAD;
        rb_wren       = ld_valid && ld_ready;
        rb_address_in = ld_ready ? ptr : '0;
        rb_data_in    = ld_ready ? ld_data : '0;
        rb_address_a  = state == DUMP ? ptr : '0;
        rb_address_b  = state == DUMP ? ptr + 1'b1 : '0;
        busy          = state != IDLE;
        done          = state == DONE;
    end

    // Pointer, remaining count and the dump output register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            cnt       <= '0;
            pad       <= 1'b0;
            issued    <= 1'b0;
            dp_valid  <= 1'b0;
            dp_data   <= '0;
            dp_last   <= 1'b0;
`ifdef REGBANK_SEQ_PARITY_EN
            dp_parity <= 2'b00;
`endif
        end else begin
            if (cmd_hs) begin
                ptr    <= cmd_base;
                cnt    <= cmd_op ? cmd_len >> 1 : cmd_len;
                pad    <= ~cmd_len[0];
                issued <= 1'b0;
            end
            if (ld_hs) begin
                ptr <= ptr + 1'b1;
                cnt <= cnt - 1'b1;
            end
            if (dp_load) begin
                dp_data   <= {rb_q_a, dp_lo};
                dp_last   <= final_beat;
                dp_valid  <= 1'b1;
                ptr       <= ptr + 2'd2;
                cnt       <= cnt - 1'b1;
                issued    <= final_beat;
`ifdef REGBANK_SEQ_PARITY_EN
                dp_parity <= {^rb_q_a, ^dp_lo};
`endif
            end else if (dp_hs) begin
                dp_valid <= 1'b0;
                dp_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regbank_sequencer.sv
// tb_regbank_sequencer: directed bench for regbank_sequencer with a behavioural register bank.
module tb_regbank_sequencer;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_op;
    logic [3:0]  cmd_base, cmd_len;
    logic        ld_valid, ld_ready;
    logic [15:0] ld_data;
    logic [3:0]  rb_address_in, rb_address_a, rb_address_b;
    logic [15:0] rb_data_in, rb_q_a, rb_q_b;
    logic        rb_wren;
    logic        dp_valid, dp_ready, dp_last, busy, done;
    logic [31:0] dp_data;
`ifdef REGBANK_SEQ_PARITY_EN
    logic [1:0]  dp_parity;
`endif
    logic [15:0] bank [16];
    logic [15:0] wbuf [16];
    logic [31:0] ebuf [8];
    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    // Register bank: synchronous write, combinational reads, no reset
    always @(posedge clock) if (rb_wren) bank[rb_address_in] <= rb_data_in;
    assign rb_q_a = bank[rb_address_a];
    assign rb_q_b = bank[rb_address_b];

    regbank_sequencer dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .rb_address_in(rb_address_in), .rb_data_in(rb_data_in), .rb_wren(rb_wren),
        .rb_address_a(rb_address_a), .rb_address_b(rb_address_b),
        .rb_q_a(rb_q_a), .rb_q_b(rb_q_b),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_data(dp_data), .dp_last(dp_last),
`ifdef REGBANK_SEQ_PARITY_EN
        .dp_parity(dp_parity),
`endif
        .busy(busy), .done(done)
    );

    task automatic issue(input logic op, input logic [3:0] base, input logic [3:0] len);
        @(posedge clock); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len;
        @(negedge clock);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_load(input logic [3:0] base, input logic [3:0] len, input bit gap);
        logic [3:0] a;
        issue(1'b0, base, len);
        for (int i = 0; i <= int'(len); i++) begin
            if (gap && i % 2 == 1) begin
                ld_valid = 1'b0;
                @(negedge clock);
                vectors++;
                if (rb_wren !== 1'b0) begin
                    miscompares++;
                    $display("FAIL load_gap_wren: rb_wren=%b required 0", rb_wren);
                end
                @(posedge clock); #1;
            end
            ld_valid = 1'b1; ld_data = wbuf[i];
            a = base + 4'(i);
            @(negedge clock);
            vectors++;
            if (rb_wren !== 1'b1 || rb_address_in !== a || rb_data_in !== wbuf[i]) begin
                miscompares++;
                $display("FAIL load_write[%0d]: wren=%b addr=%0d data=%h required 1 %0d %h",
                         i, rb_wren, rb_address_in, rb_data_in, a, wbuf[i]);
            end
            @(posedge clock); #1;
        end
        ld_valid = 1'b0;
        @(negedge clock);
        vectors++;
        if (done !== 1'b1 || rb_wren !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL load_done: done=%b wren=%b busy=%b required 1 0 1", done, rb_wren, busy);
        end
        @(posedge clock); #1;
        @(negedge clock);
        vectors++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL load_idle: done=%b ready=%b busy=%b required 0 1 0", done, cmd_ready, busy);
        end
        for (int i = 0; i <= int'(len); i++) begin
            a = base + 4'(i);
            vectors++;
            if (bank[a] !== wbuf[i]) begin
                miscompares++;
                $display("FAIL load_bank[%0d]: R=%h required %h", a, bank[a], wbuf[i]);
            end
        end
    endtask

    task automatic run_dump(input logic [3:0] base, input logic [3:0] len, input int stall_beat,
                            input int stall_cycles);
        int n, k;
        n = int'(len) / 2 + 1;
        dp_ready = 1'b1;
        issue(1'b1, base, len);
        for (int b = 0; b < n; b++) begin
            k = 0;
            @(negedge clock);
            while (!dp_valid && k < 10) begin
                @(negedge clock);
                k++;
            end
            vectors++;
            if (dp_valid !== 1'b1 || k != (b == 0 ? 1 : 0)) begin
                miscompares++;
                $display("FAIL dump_latency[%0d]: valid=%b wait=%0d required 1 %0d", b, dp_valid, k, b == 0 ? 1 : 0);
            end
            vectors++;
            if (dp_data !== ebuf[b] || dp_last !== (b == n - 1)) begin
                miscompares++;
                $display("FAIL dump_beat[%0d]: data=%h last=%b required %h %b", b, dp_data, dp_last, ebuf[b], b == n - 1);
            end
`ifdef REGBANK_SEQ_PARITY_EN
            vectors++;
            if (dp_parity !== {^ebuf[b][31:16], ^ebuf[b][15:0]}) begin
                miscompares++;
                $display("FAIL dump_parity[%0d]: parity=%b required %b", b, dp_parity, {^ebuf[b][31:16], ^ebuf[b][15:0]});
            end
`endif
            if (b == stall_beat) begin
                dp_ready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    @(posedge clock); #1;
                    @(negedge clock);
                    vectors++;
                    if (dp_valid !== 1'b1 || dp_data !== ebuf[b] || dp_last !== (b == n - 1)) begin
                        miscompares++;
                        $display("FAIL dump_hold[%0d.%0d]: valid=%b data=%h last=%b required 1 %h %b",
                                 b, s, dp_valid, dp_data, dp_last, ebuf[b], b == n - 1);
                    end
                end
                dp_ready = 1'b1;
            end
            @(posedge clock); #1;
        end
        @(negedge clock);
        vectors++;
        if (dp_valid !== 1'b0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL dump_done: valid=%b done=%b required 0 1", dp_valid, done);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ld_valid = 1'b1; ld_data = 16'hFFFF; cmd_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        vectors++;
        if (cmd_ready !== 1'b1 || ld_ready !== 1'b0 || rb_wren !== 1'b0 || dp_valid !== 1'b0 ||
            dp_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: ready=%b ldr=%b wren=%b dpv=%b last=%b busy=%b done=%b required 1 0 0 0 0 0 0",
                     cmd_ready, ld_ready, rb_wren, dp_valid, dp_last, busy, done);
        end
        vectors++;
        if (rb_address_in !== 4'd0 || rb_address_a !== 4'd0 || rb_address_b !== 4'd0 ||
            rb_data_in !== 16'd0 || dp_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_data: ain=%0d aa=%0d ab=%0d din=%h dp=%h required all 0",
                     rb_address_in, rb_address_a, rb_address_b, rb_data_in, dp_data);
        end
`ifdef REGBANK_SEQ_PARITY_EN
        vectors++;
        if (dp_parity !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_parity: parity=%b required 00", dp_parity);
        end
`endif
        @(posedge clock); #1;
        ld_valid = 1'b0; reset_n = 1'b1;
    endtask

    task automatic test_load();
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
        run_load(4'd2, 4'd3, 1'b0);
    endtask

    task automatic test_dump();
        ebuf[0] = 32'h11112222; ebuf[1] = 32'h33334444;
        run_dump(4'd2, 4'd3, -1, 0);
    endtask

    task automatic test_wrap_odd();
        wbuf[0] = 16'hAAAA; wbuf[1] = 16'hBBBB; wbuf[2] = 16'hCCCC;
        run_load(4'd15, 4'd2, 1'b0);
        ebuf[0] = 32'hAAAABBBB; ebuf[1] = 32'hCCCC0000;
        run_dump(4'd15, 4'd2, -1, 0);
    endtask

    task automatic test_backpressure();
        ebuf[0] = 32'h11112222; ebuf[1] = 32'h33334444;
        run_dump(4'd2, 4'd3, 0, 3);
    endtask

    task automatic test_load_gaps();
        wbuf[0] = 16'h5A01; wbuf[1] = 16'h5A02; wbuf[2] = 16'h5A03; wbuf[3] = 16'h5A04; wbuf[4] = 16'h5A05;
        run_load(4'd9, 4'd4, 1'b1);
        ebuf[0] = 32'h5A015A02; ebuf[1] = 32'h5A035A04; ebuf[2] = 32'h5A050000;
        run_dump(4'd9, 4'd4, 1, 2);
    endtask

    task automatic test_busy_cmd();
        issue(1'b0, 4'd6, 4'd1);
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = 4'd0; cmd_len = 4'd15;
        repeat (2) begin
            @(negedge clock);
            vectors++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1 || ld_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_cmd: ready=%b busy=%b ldr=%b required 0 1 1", cmd_ready, busy, ld_ready);
            end
            @(posedge clock); #1;
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_data = 16'h7700 + 16'(i);
            @(negedge clock);
            vectors++;
            if (rb_wren !== 1'b1 || rb_address_in !== 4'(6 + i)) begin
                miscompares++;
                $display("FAIL busy_load[%0d]: wren=%b addr=%0d required 1 %0d", i, rb_wren, rb_address_in, 6 + i);
            end
            @(posedge clock); #1;
        end
        ld_valid = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
        end
        @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || dp_valid !== 1'b0 || bank[6] !== 16'h7700 || bank[7] !== 16'h7701) begin
            miscompares++;
            $display("FAIL busy_no_latch: busy=%b dpv=%b R6=%h R7=%h required 0 0 7700 7701",
                     busy, dp_valid, bank[6], bank[7]);
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 4'd8, 4'd7);
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_data = 16'hC0D0 + 16'(i);
            @(posedge clock); #1;
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (rb_wren !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || ld_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_load: wren=%b busy=%b ready=%b ldr=%b required 0 0 1 0",
                     rb_wren, busy, cmd_ready, ld_ready);
        end
        vectors++;
        if (bank[8] !== 16'hC0D0 || bank[9] !== 16'hC0D1) begin
            miscompares++;
            $display("FAIL reset_mid_bank: R8=%h R9=%h required c0d0 c0d1", bank[8], bank[9]);
        end
        @(posedge clock); #1;
        ld_valid = 1'b0; reset_n = 1'b1;
        dp_ready = 1'b0;
        issue(1'b1, 4'd2, 4'd3);
        dp_ready = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        vectors++;
        if (dp_valid !== 1'b1 || dp_data !== 32'h11112222) begin
            miscompares++;
            $display("FAIL reset_mid_pending: valid=%b data=%h required 1 11112222", dp_valid, dp_data);
        end
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (dp_valid !== 1'b0 || dp_data !== 32'd0 || dp_last !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_dump: valid=%b data=%h last=%b busy=%b required 0 0 0 0",
                     dp_valid, dp_data, dp_last, busy);
        end
        @(posedge clock); #1;
        reset_n = 1'b1; dp_ready = 1'b1;
    endtask

    task automatic test_parity();
        wbuf[0] = 16'h0001; wbuf[1] = 16'h0003;
        run_load(4'd0, 4'd1, 1'b0);
        ebuf[0] = 32'h00010003;
        run_dump(4'd0, 4'd1, -1, 0);
`ifdef REGBANK_SEQ_PARITY_EN
        vectors++;
        if (dp_parity !== 2'b10) begin
            miscompares++;
            $display("FAIL parity_hold: parity=%b required 10", dp_parity);
        end
`endif
    endtask

    initial begin
        cmd_op = 1'b0; cmd_base = '0; cmd_len = '0; dp_ready = 1'b1; ld_data = '0;
        test_reset();
        test_load();
        test_dump();
        test_wrap_odd();
        test_backpressure();
        test_load_gaps();
        test_busy_cmd();
        test_reset_mid();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
